mfp_sevenseg_bcdconv: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the Nexys4 DDR seven-segment timer. It accepts a 27-bit unsigned binary value, converts it to eight packed BCD digits with an iterative shift-add-3 (double-dabble) datapath, and produces the timer's `DIGITS` word and active-low `EN` digit mask. Outputs are registered and change only on conversion completion, so the multiplexed display never shows intermediate values.

---
 rtl/mfp_sevenseg_bcdconv_pkg.sv | 57 +++++
 rtl/mfp_sevenseg_bcdconv_if.sv | 44 ++++
 rtl/mfp_sevenseg_bcdconv_add3.sv | 21 ++
 rtl/mfp_sevenseg_bcdconv.sv | 148 ++++++++++++++
 tb/tb_mfp_sevenseg_bcdconv.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mfp_sevenseg_bcdconv_pkg.sv
// ---------------------------------------------------------------------------
// mfp_sevenseg_pkg
// Shared constants, FSM encoding and the leading-zero blank-mask helper for
// the seven-segment binary-to-BCD converter.
//   SEG_NDIG        number of BCD digits on the display
//   SEG_BIN_W       binary input width (smallest width covering 99_999_999)
//   SEG_MAX_VAL     largest value representable on eight digits
//   SEG_OVF_DIGITS  pattern shown when the input does not fit
//   state_e         converter FSM states
// ---------------------------------------------------------------------------
package mfp_sevenseg_pkg;

  localparam int unsigned SEG_NDIG  = 8;
  localparam int unsigned SEG_BIN_W = 27;
  localparam int unsigned SEG_DIG_W = 4 * SEG_NDIG;
  localparam int unsigned SEG_CNT_W = 5;

  localparam logic [SEG_BIN_W-1:0] SEG_MAX_VAL    = 27'd99_999_999;
  localparam logic [SEG_DIG_W-1:0] SEG_OVF_DIGITS = 32'h9999_9999;

  // Iteration counter load: one iteration per binary input bit.
  localparam logic [SEG_CNT_W-1:0] SEG_CNT_LOAD = SEG_CNT_W'(SEG_BIN_W - 1);

  // EN reset values for the blanking and non-blanking builds.
  localparam logic [SEG_NDIG-1:0] SEG_EN_RST_BLANK = 8'hFE;
  localparam logic [SEG_NDIG-1:0] SEG_EN_ALL_ON    = 8'h00;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  // Active-low digit enables with leading-zero blanking. A digit is blanked
  // when it and every more significant digit are zero; digit 0 is always lit
  // so a zero value still shows "0". Overflow lights everything.
  function automatic logic [SEG_NDIG-1:0] blank_mask(
    input logic [SEG_DIG_W-1:0] digits,
    input logic                 ovf
  );
    logic [SEG_NDIG-1:0] m;
    logic                zero_above;
    int unsigned         idx;
    m          = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < SEG_NDIG - 1; k++) begin
      idx        = SEG_NDIG - 1 - k;
      zero_above = zero_above & (digits[4*idx +: 4] == 4'd0);
      m[idx]     = zero_above;
    end
    m[0] = 1'b0;
    if (ovf) begin
      m = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/mfp_sevenseg_bcdconv_if.sv
// ---------------------------------------------------------------------------
// mfp_sevenseg_bcdconv_if
// Request/result bundle between a value producer and the BCD converter.
//   start   conversion request (sampled by the converter only when idle)
//   value   binary value to convert, captured with an accepted start
//   busy    converter is iterating
//   done    one-cycle pulse when DIGITS/EN/ovf update
//   ovf     last captured value exceeded 99_999_999
//   DIGITS  packed BCD, digit i in bits [4i+3:4i]
//   EN      active-low digit enables, bit i lights digit i
// Modports: master drives the request, slave is the converter.
// ---------------------------------------------------------------------------
interface mfp_sevenseg_bcdconv_if;
  import mfp_sevenseg_pkg::*;

  logic                 start;
  logic [SEG_BIN_W-1:0] value;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic [SEG_DIG_W-1:0] DIGITS;
  logic [SEG_NDIG-1:0]  EN;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  ovf,
    input  DIGITS,
    input  EN
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output ovf,
    output DIGITS,
    output EN
  );

endinterface

// File: rtl/mfp_sevenseg_bcdconv_add3.sv
// ---------------------------------------------------------------------------
// mfp_bcd_add3
// Combinational double-dabble digit corrector: adds 3 to a BCD digit of 5 or
// more so that the following left shift carries correctly into the next
// digit. Inputs 5..9 map to 8..12, so the result never leaves four bits.
//   d_i  BCD digit before correction
//   q_o  corrected digit
// ---------------------------------------------------------------------------
module mfp_bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  always_comb begin
    q_o = d_i;
    if (d_i >= 4'd5) begin
      q_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/mfp_sevenseg_bcdconv.sv
// ---------------------------------------------------------------------------
// mfp_sevenseg_bcdconv
// Sequential binary-to-BCD converter feeding the Nexys4 DDR seven-segment
// timer. A captured 27-bit value is converted with one shift-add-3 iteration
// per clock (27 clocks), then DIGITS/EN/ovf are committed together with a
// one-cycle done pulse so the display never shows partial results.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     mfp_sevenseg_bcdconv_if.slave (start/value in; busy/done/ovf/
//           DIGITS/EN out)
// Configuration macro:
//   MFP_SEVENSEG_BLANK_EN  defined: leading-zero blanking on EN (reset FE);
//                          undefined: EN tied to 8'h00.
// ---------------------------------------------------------------------------
module mfp_sevenseg_bcdconv
  import mfp_sevenseg_pkg::*;
#(
  parameter int unsigned BIN_W = SEG_BIN_W,
  parameter int unsigned NDIG  = SEG_NDIG
) (
  input logic                   clk,
  input logic                   resetn,
  mfp_sevenseg_bcdconv_if.slave bus
);

  localparam int unsigned DW = 4 * NDIG;

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic [DW-1:0]        bcd_adj;
  logic [DW:0]          bcd_shift;
  logic [SEG_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovf_n_q, ovf_n_d;
  logic [DW-1:0]        digits_q, digits_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 commit;
  logic [DW-1:0]        commit_val;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    mfp_bcd_add3 u_add3 (
      .d_i (bcd_q[4*g +: 4]),
      .q_o (bcd_adj[4*g +: 4])
    );
  end

  // {bcd, bin} shifted left by one with bin's MSB entering bcd[0].
  assign bcd_shift  = {bcd_adj, bin_q[BIN_W-1]};
  assign commit_val = ovf_n_q ? SEG_OVF_DIGITS : bcd_shift[DW-1:0];

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    ovf_n_d  = ovf_n_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    commit   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          ovf_n_d = (bus.value > SEG_MAX_VAL);
          cnt_d   = SEG_CNT_LOAD;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = bcd_shift[DW-1:0];
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - SEG_CNT_W'(1);
        // A carry out of the top digit only happens for inputs already
        // flagged as overflow; folding it in keeps the flag sticky.
        ovf_n_d = ovf_n_q | bcd_shift[DW];
        if (cnt_q == '0) begin
          commit   = 1'b1;
          digits_d = commit_val;
          ovf_d    = ovf_n_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_n_q  <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      ovf_n_q  <= ovf_n_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == S_CONV);
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.DIGITS = digits_q;

`ifdef MFP_SEVENSEG_BLANK_EN
  logic [NDIG-1:0] en_q, en_d;

  // The mask is derived from the value being committed, not from DIGITS,
  // so EN and DIGITS change on the same edge.
  always_comb begin
    en_d = en_q;
    if (commit) begin
      en_d = blank_mask(commit_val, ovf_n_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q <= SEG_EN_RST_BLANK;
    end else begin
      en_q <= en_d;
    end
  end

  assign bus.EN = en_q;
`else
  assign bus.EN = SEG_EN_ALL_ON;
`endif

endmodule

// File: tb/tb_mfp_sevenseg_bcdconv.sv
// ---------------------------------------------------------------------------
// tb_mfp_sevenseg_bcdconv
// Directed bench for the BCD converter. Stimulus pushes the expected commit
// into a queue; an independent monitor pops and compares on every done pulse.
// Build with or without MFP_SEVENSEG_BLANK_EN to match the RTL.
// ---------------------------------------------------------------------------
module tb_mfp_sevenseg_bcdconv;
  import mfp_sevenseg_pkg::*;

`ifdef MFP_SEVENSEG_BLANK_EN
  localparam logic [7:0] RST_EN = 8'hFE;
  localparam bit         BLANK  = 1'b1;
`else
  localparam logic [7:0] RST_EN = 8'h00;
  localparam bit         BLANK  = 1'b0;
`endif

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  en;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [26:0] v;
    logic [31:0] d;
    logic [7:0]  en_blank;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] prev_digits = 32'h0;

  always #5 clk = ~clk;

  mfp_sevenseg_bcdconv_if bus ();

  mfp_sevenseg_bcdconv #(.BIN_W(27), .NDIG(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pick_en(input logic [7:0] en_blank);
    return BLANK ? en_blank : 8'h00;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with DIGITS=%h expected no done", bus.DIGITS);
        end else begin
          e = exp_q.pop_front();
          check("digits", bus.DIGITS, e.digits);
          check("en", {24'h0, bus.EN}, {24'h0, e.en});
          check("ovf", {31'h0, bus.ovf}, {31'h0, e.ovf});
        end
      end
    end
  end

  // Requests a conversion once the converter is idle; returns #1 after the
  // accepting edge.
  task automatic issue(input logic [26:0] v, input bit push, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %b expected 0", bus.busy);
    end
    if (push) exp_q.push_back(e);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Full conversion with latency, busy-window and hold checks.
  task automatic run_conv(input vec_t t);
    exp_t e;
    int   busy_cnt;
    int   done_idx;
    e.digits = t.d;
    e.en     = pick_en(t.en_blank);
    e.ovf    = t.ovf;
    issue(t.v, 1'b1, e);
    busy_cnt = 0;
    done_idx = -1;
    for (int k = 0; k <= 27; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1 && done_idx < 0) done_idx = k;
      if (k == 13) check("hold_digits", bus.DIGITS, prev_digits);
      if (k < 27) begin
        @(posedge clk);
        #1;
      end
    end
    check("busy_cycles", busy_cnt, 27);
    check("done_latency", done_idx, 27);
    prev_digits = t.d;
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v42, vrst;
    exp_t e, none;
    int   n;

    vecs[0] = '{27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0};
    vecs[1] = '{27'd1_005,       32'h0000_1005, 8'hF0, 1'b0};
    vecs[2] = '{27'd0,           32'h0000_0000, 8'hFE, 1'b0};
    vecs[3] = '{27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0};
    vecs[4] = '{27'd100_000_000, 32'h9999_9999, 8'h00, 1'b1};
    v42     = '{27'd42,          32'h0000_0042, 8'hFC, 1'b0};
    vrst    = '{27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0};
    none    = '{32'h0, 8'h0, 1'b0};

    bus.start = 1'b0;
    bus.value = '0;

    // Reset state, during and after reset with no request.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_ovf", {31'h0, bus.ovf}, 32'h0);
    check("rst_digits", bus.DIGITS, 32'h0);
    check("rst_en", {24'h0, bus.EN}, {24'h0, RST_EN});
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'h0, bus.busy}, 32'h0);
    check("idle_digits", bus.DIGITS, 32'h0);
    check("idle_en", {24'h0, bus.EN}, {24'h0, RST_EN});

    // Main directed vectors, including the 8-digit boundary and overflow.
    foreach (vecs[i]) run_conv(vecs[i]);

    // Second start while converting 42 must be ignored.
    e.digits = v42.d;
    e.en     = pick_en(v42.en_blank);
    e.ovf    = 1'b0;
    issue(v42.v, 1'b1, e);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.value = 27'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ignore_drain", exp_q.size(), 0);
    repeat (35) @(negedge clk);
    check("ignore_digits", bus.DIGITS, 32'h0000_0042);
    check("ignore_busy", {31'h0, bus.busy}, 32'h0);

    // Reset in the middle of a conversion discards it; no done follows.
    issue(vrst.v, 1'b0, none);
    repeat (15) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrst_digits", bus.DIGITS, 32'h0);
    check("midrst_ovf", {31'h0, bus.ovf}, 32'h0);
    check("midrst_en", {24'h0, bus.EN}, {24'h0, RST_EN});
    @(negedge clk);
    resetn = 1'b1;
    repeat (35) @(negedge clk);
    check("postrst_digits", bus.DIGITS, 32'h0);
    prev_digits = 32'h0;
    run_conv(vrst);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
